// File: rtl/spi_cmd_decoder_if.sv
// rtl/spi_cmd_decoder_if.sv - word handoff from the SPI slave to the command decoder
interface spi_cmd_decoder_if;
    logic [15:0] word_data;
    logic        word_valid;

    modport master (output word_data, output word_valid);
    modport slave  (input  word_data, input  word_valid);
endinterface

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - decodes SPI command words into PWM duties, stepper target and link watchdog
module spi_cmd_decoder #(
    parameter int NUM_CH      = 10,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk50M,
    input  logic                  rst,
    spi_cmd_decoder_if.slave      word_if,
    output logic [8*NUM_CH-1:0]   duty_flat,
    output logic [7:0]            angle_target,
    output logic                  angle_stb,
    output logic                  cmd_ack,
    output logic [7:0]            err_cnt,
    output logic                  failsafe
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

    localparam int             WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic            wv_q, wv_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [7:0]      duty_q [NUM_CH];
    logic [7:0]      duty_d [NUM_CH];
    logic [7:0]      angle_q, angle_d;
    logic            stb_q, stb_d;
    logic            ack_q, ack_d;
    logic [7:0]      err_q, err_d;
    logic            fs_q, fs_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic [3:0] op;
    logic [3:0] ch;
    logic [7:0] val;
    logic       new_word;
    logic       ch_ok;
    logic       accept;

    assign op       = cmd_q[15:12];
    assign ch       = cmd_q[11:8];
    assign val      = cmd_q[7:0];
    assign new_word = word_if.word_valid & ~wv_q;
    assign ch_ok    = ({1'b0, ch} < 5'(NUM_CH));

    always_comb begin
        accept = 1'b0;
        case (op)
            4'h0, 4'h2, 4'h3: accept = 1'b1;
            4'h1:             accept = ch_ok;
            default:          accept = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wv_d    = word_if.word_valid;
        cmd_d   = cmd_q;
        duty_d  = duty_q;
        angle_d = angle_q;
        stb_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = err_q;
        fs_d    = fs_q;
        wd_d    = wd_q;

        unique case (state_q)
            IDLE: begin
                if (new_word) begin
                    cmd_d   = word_if.word_data;
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!fs_q) begin
            if (wd_q == WD_LAST) begin
                fs_d = 1'b1;
                for (int k = 0; k < NUM_CH; k++) duty_d[k] = 8'h00;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        // The command commits on the DECODE->EXEC edge, so its effects show in EXEC;
        // an accepted command overrides a watchdog expiry landing on the same edge.
        if (state_q == DECODE) begin
            if (accept) begin
                duty_d = duty_q;
                ack_d  = 1'b1;
                fs_d   = 1'b0;
                wd_d   = '0;
                case (op)
                    4'h1: begin
                        for (int k = 0; k < NUM_CH; k++)
                            if (ch == 4'(k)) duty_d[k] = val;
                    end
                    4'h2: begin
                        angle_d = val;
                        stb_d   = 1'b1;
                    end
                    4'h3: begin
                        for (int k = 0; k < NUM_CH; k++) duty_d[k] = 8'h00;
                    end
                    default: ;
                endcase
            end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q <= IDLE;
            wv_q    <= 1'b1;
            cmd_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) duty_q[k] <= 8'h00;
            angle_q <= '0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= '0;
            fs_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wv_q    <= wv_d;
            cmd_q   <= cmd_d;
            for (int k = 0; k < NUM_CH; k++) duty_q[k] <= duty_d[k];
            angle_q <= angle_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            fs_q    <= fs_d;
            wd_q    <= wd_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign duty_flat[8*g +: 8] = duty_q[g];
    end

    assign angle_target = angle_q;
    assign angle_stb    = stb_q;
    assign cmd_ack      = ack_q;
    assign err_cnt      = err_q;
    assign failsafe     = fs_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - scoreboard bench for spi_cmd_decoder
module tb_spi_cmd_decoder;
    localparam int NCH = 10;

    logic clk50M;
    logic rst;
    logic [8*NCH-1:0] duty_flat;
    logic [7:0] angle_target;
    logic       angle_stb;
    logic       cmd_ack;
    logic [7:0] err_cnt;
    logic       failsafe;

    spi_cmd_decoder_if wif();

    spi_cmd_decoder #(.NUM_CH(NCH), .TIMEOUT_CYC(16)) dut (
        .clk50M       (clk50M),
        .rst          (rst),
        .word_if      (wif),
        .duty_flat    (duty_flat),
        .angle_target (angle_target),
        .angle_stb    (angle_stb),
        .cmd_ack      (cmd_ack),
        .err_cnt      (err_cnt),
        .failsafe     (failsafe)
    );

    typedef struct {
        int             cyc;
        logic [8*NCH-1:0] duty;
        logic [7:0]     ang;
        logic           stb;
        logic           ack;
        logic [7:0]     err;
        logic           fs;
        logic           chk_fs;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic finish_req = 1'b0;
    logic finish_ack = 1'b0;

    logic [7:0] m_duty [NCH];
    logic [7:0] m_ang;
    logic [7:0] m_err;
    logic       m_fs;

    initial begin
        clk50M = 1'b0;
        forever #5 clk50M = ~clk50M;
    end

    initial forever begin
        @(posedge clk50M);
        cyc++;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench did not reach its end, cyc=%0d required finish", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input logic ack, input logic stb, input logic chk_fs, input string name);
        exp_t e;
        e.cyc = c;
        for (int k = 0; k < NCH; k++) e.duty[8*k +: 8] = m_duty[k];
        e.ang    = m_ang;
        e.stb    = stb;
        e.ack    = ack;
        e.err    = m_err;
        e.fs     = m_fs;
        e.chk_fs = chk_fs;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) m_duty[k] = 8'h00;
        m_ang = 8'h00;
        m_err = 8'h00;
        m_fs  = 1'b0;
    endtask

    // Word edge in cycle n; results expected at n+2, pulses gone at n+3.
    task automatic send_word(input logic [15:0] w, input logic ack, input logic stb,
                             input logic chk_fs, input string name, output int n);
        tick();
        wif.word_data  = w;
        wif.word_valid = 1'b1;
        n = cyc;
        push(n + 2, ack, stb, chk_fs, name);
        push(n + 3, 1'b0, 1'b0, chk_fs, {name, "_after"});
        tick();
        tick();
        wif.word_valid = 1'b0;
        tick();
    endtask

    initial forever begin
        @(negedge clk50M);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_cmp++;
                if (sb[i].cyc < cyc || duty_flat !== sb[i].duty || angle_target !== sb[i].ang ||
                    angle_stb !== sb[i].stb || cmd_ack !== sb[i].ack || err_cnt !== sb[i].err ||
                    (sb[i].chk_fs && failsafe !== sb[i].fs)) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got duty=%h ang=%h stb=%b ack=%b err=%0d fs=%b; expected duty=%h ang=%h stb=%b ack=%b err=%0d fs=%b (at cyc %0d)",
                             sb[i].name, cyc, duty_flat, angle_target, angle_stb, cmd_ack, err_cnt, failsafe,
                             sb[i].duty, sb[i].ang, sb[i].stb, sb[i].ack, sb[i].err, sb[i].fs, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
        if (finish_req && !finish_ack) begin
            n_cmp++;
            if (sb.size() != 0) begin
                n_bad++;
                $display("FAIL leftover_expectations: got %0d pending, expected 0", sb.size());
            end
            finish_ack = 1'b1;
        end
    end

    initial begin
        int n, n9, n10, r2;
        rst = 1'b1;
        wif.word_data  = 16'h0000;
        wif.word_valid = 1'b0;
        clear_model();
        repeat (3) tick();
        rst = 1'b0;
        push(cyc, 1'b0, 1'b0, 1'b1, "reset_state");

        m_duty[3] = 8'h80;
        send_word(16'h1380, 1'b1, 1'b0, 1'b1, "set_duty_ch3", n);
        m_err = 8'd1;
        send_word(16'h1A55, 1'b0, 1'b0, 1'b1, "bad_channel", n);
        m_ang = 8'h5A;
        send_word(16'h205A, 1'b1, 1'b1, 1'b1, "set_angle", n);
        m_duty[3] = 8'h00;
        send_word(16'h3000, 1'b1, 1'b0, 1'b1, "all_off", n);

        for (int i = 2; i <= 256; i++) begin
            m_err = (i > 255) ? 8'd255 : 8'(i);
            send_word((i % 2 == 0) ? 16'h1A55 : 16'h7123, 1'b0, 1'b0, 1'b0, "err_burst", n);
        end
        m_fs = 1'b1;
        push(cyc, 1'b0, 1'b0, 1'b1, "failsafe_after_idle");
        m_fs = 1'b0;
        send_word(16'h0000, 1'b1, 1'b0, 1'b1, "nop_exit_failsafe", n);

        m_duty[0] = 8'hFF;
        send_word(16'h10FF, 1'b1, 1'b0, 1'b1, "set_ch0_ff", n);
        push(n + 17, 1'b0, 1'b0, 1'b1, "wd_one_before");
        m_duty[0] = 8'h00;
        m_fs = 1'b1;
        push(n + 18, 1'b0, 1'b0, 1'b1, "wd_expired");
        wait_until(n + 19);
        m_fs = 1'b0;
        send_word(16'h0000, 1'b1, 1'b0, 1'b1, "nop_clear_fs", n9);

        wait_until(n9 + 15);
        m_duty[1] = 8'h22;
        send_word(16'h1122, 1'b1, 1'b0, 1'b1, "cmd_beats_expiry", n10);
        push(n10 + 17, 1'b0, 1'b0, 1'b1, "wd_reloaded");
        m_duty[1] = 8'h00;
        m_fs = 1'b1;
        push(n10 + 18, 1'b0, 1'b0, 1'b1, "wd_expired2");

        wait_until(n10 + 20);
        rst = 1'b1;
        wif.word_data  = 16'h1380;
        wif.word_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        r2 = cyc;
        clear_model();
        for (int k = 0; k < 5; k++) push(r2 + k, 1'b0, 1'b0, 1'b1, "valid_held_over_reset");
        wait_until(r2 + 5);
        wif.word_valid = 1'b0;
        tick();

        m_duty[3] = 8'h80;
        send_word(16'h1380, 1'b1, 1'b0, 1'b1, "reapply_ch3", n);
        m_err = 8'd1;
        send_word(16'h1A55, 1'b0, 1'b0, 1'b1, "bad_channel2", n);
        m_ang = 8'h77;
        send_word(16'h2077, 1'b1, 1'b1, 1'b1, "set_angle2", n);

        tick();
        wif.word_data  = 16'h1440;
        wif.word_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        push(cyc, 1'b0, 1'b0, 1'b1, "abort_in_decode");
        push(cyc + 1, 1'b0, 1'b0, 1'b1, "abort_in_decode_late");
        tick();
        wif.word_valid = 1'b0;
        repeat (3) tick();

        finish_req = 1'b1;
        for (int i = 0; i < 10 && !finish_ack; i++) tick();
        if (!finish_ack) begin
            $display("FAIL monitor_handshake: got no acknowledge, expected one within 10 cycles");
            $fatal(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter NUM_CH, default 10: number of PWM duty channels decoded (1..16).
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000: link-loss watchdog period in clk50M cycles (1 s).
REQ-003 clk50M  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 word_data  input  16  last word assembled by the SPI slave; stable while word_valid is high.
REQ-006 word_valid  input  1  level from the SPI slave, already in the clk50M domain; a new word is signalled by its 0->1 transition.
REQ-007 duty_flat  output  8*NUM_CH  packed duty values; channel k occupies bits [8k+7:8k].
REQ-008 angle_target  output  8  last commanded stepper target.
REQ-009 angle_stb  output  1  one-cycle pulse when angle_target is updated.
REQ-010 cmd_ack  output  1  one-cycle pulse per accepted (non-error) command.
REQ-011 err_cnt  output  8  count of rejected commands, saturating.
REQ-012 failsafe  output  1  high while the watchdog has expired and no valid command has arrived since.

Function
REQ-013 The block shall register word_valid each cycle and detect a new word when the current value is 1 and the registered value is 0.
REQ-014 On detection in cycle N, the block shall capture word_data into a command register in cycle N and decode it in cycle N+1.
REQ-015 Outputs and pulses caused by the command shall be visible in cycle N+2, giving a fixed latency of 2 cycles.
REQ-016 The FSM shall have three states: IDLE, DECODE and EXEC.
REQ-017 FSM transitions: IDLE->DECODE on detection; DECODE->EXEC unconditionally; EXEC->IDLE unconditionally.
REQ-018 The block shall ignore an edge that arrives while the FSM is not in IDLE; the SPI word rate guarantees at least 3 cycles between edges.
REQ-019 Word format: opcode = [15:12], channel = [11:8], value = [7:0].
REQ-020 Opcode 0x0 (NOP) shall only refresh the watchdog.
REQ-021 Opcode 0x1 (SET_DUTY) with channel < NUM_CH shall write value into that channel's duty.
REQ-022 Opcode 0x1 with channel >= NUM_CH shall be rejected as an error.
REQ-023 Opcode 0x2 (SET_ANGLE) shall set angle_target to value and pulse angle_stb.
REQ-024 Opcode 0x3 (ALL_OFF) shall clear all duties to 0.
REQ-025 Opcodes 0x4-0xF shall be rejected as errors.
REQ-026 An accepted command shall pulse cmd_ack for one cycle in EXEC, reload the watchdog and clear failsafe.
REQ-027 A rejected command shall increment err_cnt, saturating at 255, and shall not pulse cmd_ack, reload the watchdog or change any duty or angle.
REQ-028 The watchdog counter shall count up every cycle while not in failsafe.
REQ-029 When the watchdog count reaches TIMEOUT_CYC-1, the block shall on the next cycle set failsafe=1, clear all duties to 0 and hold the counter.
REQ-030 In failsafe, the block shall keep duties at 0 until an accepted command arrives; that command shall apply normally.
REQ-031 If watchdog expiry and an accepted EXEC fall in the same cycle, the command shall win: no failsafe, counter reloaded to 0, command applied.
REQ-032 angle_target shall not be changed by failsafe entry.

Reset
REQ-033 While rst=1 at a clock edge, the block shall force: FSM=IDLE, registered word_valid=1, all duties=0, angle_target=0, angle_stb=0, cmd_ack=0, err_cnt=0, failsafe=0, watchdog=0, command register=0.
REQ-034 The registered word_valid reset value of 1 shall prevent a word_valid already held high at reset release from being taken as a new word.
REQ-035 rst asserted mid-command (DECODE or EXEC) shall abort the command with no output change other than the reset values.

Verification
REQ-036 After reset, word 0x1380 -> at N+2, duty ch3 = 0x80 and cmd_ack pulses once; the other duties stay 0.
REQ-037 Word 0x1A55 with NUM_CH=10 -> err_cnt = 1, no cmd_ack, all duties unchanged; 256 such words -> err_cnt = 255.
REQ-038 Word 0x205A -> angle_target = 0x5A and angle_stb is high for exactly one cycle; then 0x3000 -> all duties 0 and angle_target still 0x5A.
REQ-039 With TIMEOUT_CYC=16, set ch0=0xFF and then send no words -> failsafe=1 and ch0=0 exactly 16 cycles after the last reload; then 0x0000 -> failsafe=0 and ch0 stays 0.
REQ-040 Watchdog expiry coincides with EXEC of 0x1122 -> failsafe stays 0 and ch1 = 0x22.
REQ-041 word_valid held high across rst deassertion -> no command is executed; rst pulsed during DECODE -> all outputs return to reset values.
